branch_seq: RTL and testbench

Multi-cycle sequencer for relative conditional branches. It evaluates the branch condition from the processor status register and drives the PC unit's increment and low-byte load strobes. It also issues the page-crossing high-byte fix-up. It sits between the instruction decoder and the PC, and reproduces 6502 branch timing: 2 cycles not taken, 3 taken, 4 taken with page cross.

---
 rtl/branch_pkg.sv | 26 ++
 rtl/branch_cond.sv | 31 +++
 rtl/branch_seq.sv | 137 +++++++++++++
 tb/tb_branch_seq.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the relative-branch sequencer: state encoding,
// flag-select codes, status bit positions and page-fix direction.
package branch_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FETCH  = 2'd1;
   localparam logic [1:0] ST_ADD_LO = 2'd2;
   localparam logic [1:0] ST_FIX_HI = 2'd3;

   localparam logic [1:0] FLAG_N = 2'b00;
   localparam logic [1:0] FLAG_V = 2'b01;
   localparam logic [1:0] FLAG_C = 2'b10;
   localparam logic [1:0] FLAG_Z = 2'b11;

   localparam int STAT_N = 7;
   localparam int STAT_V = 6;
   localparam int STAT_Z = 1;
   localparam int STAT_C = 0;

   typedef enum logic [1:0] {
      PAGE_NONE = 2'd0,
      PAGE_INC  = 2'd1,
      PAGE_DEC  = 2'd2
   } page_dir_e;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition: selects one status flag, compares it with
// the required value, and lets the unconditional request force the result.
module branch_cond
   import branch_pkg::*;
(
   input  logic [2:0] branch_op,
   input  logic [7:0] status,
   input  logic       uncon,
   output logic       cond
);

   logic flag;
   logic unused_status;

   assign unused_status = ^status[5:2];

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      flag = 1'b0;
      case (branch_op[2:1])
         FLAG_N:  flag = status[STAT_N];
         FLAG_V:  flag = status[STAT_V];
         FLAG_C:  flag = status[STAT_C];
         FLAG_Z:  flag = status[STAT_Z];
         default: flag = 1'b0;
      endcase
   end

   assign cond = (flag == branch_op[0]) | uncon;

endmodule

// File: rtl/branch_seq.sv
// 6502-timed relative-branch sequencer (2/3/4 cycles). Define BRANCH_UNCON_EN
// to honour branch_uncon as an always-taken branch (65C02 BRA).
module branch_seq
   import branch_pkg::*;
#(
   parameter int OFS_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       branch_op,
   input  logic             branch_uncon,
   input  logic [7:0]       status,
   input  logic [OFS_W-1:0] offset,
   input  logic [OFS_W-1:0] pc_lo,
   output logic             busy,
   output logic             pc_increment,
   output logic             lower_byte,
   output logic [OFS_W-1:0] bra_lo,
   output logic             hi_inc,
   output logic             hi_dec,
   output logic             taken,
   output logic             done
);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [2:0]       op_q;
   logic [OFS_W-1:0] ofs_q;
   page_dir_e        dir_q;
   page_dir_e        cross_dir;
   logic [OFS_W:0]   sum;
   logic             uncon_eff;
   logic             cond;

`ifdef BRANCH_UNCON_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         uncon_eff <= 1'b0;
      else if (state == ST_IDLE && start)
         uncon_eff <= branch_uncon;
   end
`else
   logic unused_uncon;
   assign unused_uncon = branch_uncon;
   assign uncon_eff    = 1'b0;
`endif

   branch_cond u_cond (
      .branch_op (op_q),
      .status    (status),
      .uncon     (uncon_eff),
      .cond      (cond)
   );

   assign sum = {1'b0, pc_lo} + {1'b0, ofs_q};

   // A forward offset that carries, or a backward offset that does not, leaves the page.
   always_comb begin
      cross_dir = PAGE_NONE;
      if (!ofs_q[OFS_W-1] && sum[OFS_W])
         cross_dir = PAGE_INC;
      else if (ofs_q[OFS_W-1] && !sum[OFS_W])
         cross_dir = PAGE_DEC;
   end

   always_comb begin
      state_nxt    = state;
      busy         = (state != ST_IDLE);
      pc_increment = 1'b0;
      lower_byte   = 1'b0;
      bra_lo       = '0;
      hi_inc       = 1'b0;
      hi_dec       = 1'b0;
      done         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start)
               state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            pc_increment = 1'b1;
            if (cond) begin
               state_nxt = ST_ADD_LO;
            end else begin
               done      = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_ADD_LO: begin
            lower_byte = 1'b1;
            bra_lo     = sum[OFS_W-1:0];
            if (cross_dir == PAGE_NONE) begin
               done      = 1'b1;
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_FIX_HI;
            end
         end
         ST_FIX_HI: begin
            hi_inc    = (dir_q == PAGE_INC);
            hi_dec    = (dir_q == PAGE_DEC);
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         op_q  <= '0;
         ofs_q <= '0;
         taken <= 1'b0;
         dir_q <= PAGE_NONE;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_q  <= branch_op;
                  taken <= 1'b0;
               end
            end
            ST_FETCH: begin
               ofs_q <= offset;
               taken <= cond;
            end
            ST_ADD_LO: dir_q <= cross_dir;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_branch_seq.sv
// Self-checking bench for branch_seq: directed 6502 branch cases plus random
// branches checked against a PC-arithmetic reference model.
module tb_branch_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [2:0] branch_op = '0;
   logic       branch_uncon = 1'b0;
   logic [7:0] status = '0;
   logic [7:0] offset = '0;
   logic [7:0] pc_lo = '0;
   logic       busy, pc_increment, lower_byte, hi_inc, hi_dec, taken, done;
   logic [7:0] bra_lo;

   int n_cmp = 0;
   int n_bad = 0;

   branch_seq #(.OFS_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .branch_op    (branch_op),
      .branch_uncon (branch_uncon),
      .status       (status),
      .offset       (offset),
      .pc_lo        (pc_lo),
      .busy         (busy),
      .pc_increment (pc_increment),
      .lower_byte   (lower_byte),
      .bra_lo       (bra_lo),
      .hi_inc       (hi_inc),
      .hi_dec       (hi_dec),
      .taken        (taken),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Strobes packed as {busy, pc_increment, lower_byte, hi_inc, hi_dec, done}.
   function automatic logic [5:0] outs();
      return {busy, pc_increment, lower_byte, hi_inc, hi_dec, done};
   endfunction

   task automatic check_idle(input string tag, input logic exp_taken);
      check({tag, " idle strobes"}, 32'(outs()), 32'h0);
      check({tag, " idle bra_lo"}, 32'(bra_lo), 32'h0);
      check({tag, " idle taken"}, 32'(taken), 32'(exp_taken));
   endtask

   // Model: the branch target is computed as a full 16-bit PC (page 0x40) plus
   // the sign-extended offset; a page change decides the extra cycle.
   task automatic run_txn(input string tag, input logic [2:0] op, input logic unc,
                          input logic [7:0] st, input logic [7:0] ofs,
                          input logic [7:0] pcl, input bit poke);
      logic       flag, cond, up, dn;
      int         tgt, n;
      logic [5:0] ev;
      logic [7:0] eb;
      logic       et;
      case (op[2:1])
         2'b00:   flag = st[7];
         2'b01:   flag = st[6];
         2'b10:   flag = st[0];
         default: flag = st[1];
      endcase
      cond = (flag == op[0]);
`ifdef BRANCH_UNCON_EN
      cond = cond | unc;
`endif
      tgt = 'h4000 + int'(pcl) + (ofs[7] ? int'(ofs) - 256 : int'(ofs));
      up  = (tgt >> 8) > 'h40;
      dn  = (tgt >> 8) < 'h40;
      n   = !cond ? 1 : ((up || dn) ? 3 : 2);

      @(negedge clk);
      branch_op = op; branch_uncon = unc; status = st; offset = ofs; pc_lo = pcl;
      start = 1'b1;
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         start = poke && (c == 1);
         case (c)
            1:       begin ev = {5'b11000, !cond};        eb = 8'h00;     et = 1'b0; end
            2:       begin ev = {5'b10100, !(up || dn)};  eb = tgt[7:0];  et = cond; end
            default: begin ev = {3'b100, up, dn, 1'b1};   eb = 8'h00;     et = cond; end
         endcase
         check($sformatf("%s c%0d strobes", tag, c), 32'(outs()), 32'(ev));
         check($sformatf("%s c%0d bra_lo", tag, c), 32'(bra_lo), 32'(eb));
         check($sformatf("%s c%0d taken", tag, c), 32'(taken), 32'(et));
      end
      @(negedge clk);
      start = 1'b0;
      check_idle(tag, cond);
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      check_idle("reset", 1'b0);
      rst = 1'b1;

      run_txn("beq_not_taken", 3'b111, 1'b0, 8'h00, 8'h05, 8'h10, 1'b0);
      run_txn("beq_taken",     3'b111, 1'b0, 8'h02, 8'h05, 8'h10, 1'b0);
      run_txn("bcc_fwd_cross", 3'b100, 1'b0, 8'h00, 8'h04, 8'hFE, 1'b0);
      run_txn("bmi_bwd_cross", 3'b001, 1'b0, 8'h80, 8'hFC, 8'h02, 1'b0);
      run_txn("ofs_zero",      3'b100, 1'b0, 8'h00, 8'h00, 8'h80, 1'b0);
      run_txn("ff_plus_1",     3'b101, 1'b0, 8'h01, 8'h01, 8'hFF, 1'b0);
      run_txn("00_minus_1",    3'b010, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0);
      run_txn("start_busy",    3'b100, 1'b0, 8'h00, 8'h04, 8'hFE, 1'b1);
      run_txn("uncon",         3'b111, 1'b1, 8'h00, 8'h10, 8'h20, 1'b0);

      // start held high: ignored at the done edge, accepted one edge later
      @(negedge clk);
      branch_op = 3'b111; branch_uncon = 1'b0; status = 8'h00; start = 1'b1;
      @(negedge clk);
      check("b2b first fetch", 32'(outs()), 32'b110001);
      @(negedge clk);
      check("b2b gap", 32'(outs()), 32'h0);
      @(negedge clk);
      check("b2b second fetch", 32'(outs()), 32'b110001);
      start = 1'b0;
      @(negedge clk);
      check_idle("b2b end", 1'b0);

      // reset asserted during ADD_LO
      @(negedge clk);
      branch_op = 3'b100; status = 8'h00; offset = 8'h04; pc_lo = 8'hFE; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("rst pre add_lo", 32'(outs()), 32'b101000);
      #2 rst = 1'b0;
      #1;
      check_idle("rst async", 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_idle("rst released", 1'b0);

      for (int i = 0; i < 80; i++) begin
         logic [7:0] pcl;
         case ($urandom_range(0, 3))
            0:       pcl = 8'hFF;
            1:       pcl = 8'h00;
            default: pcl = 8'($urandom);
         endcase
         run_txn($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom),
                 pcl, 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
